// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: opcode width and
// the eight opcode encodings.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The master side offers operands and consumes results; the slave side is the
// unit itself. Optional macro LOGIC_UNIT_FLAGS_EN adds the oZero/oParity flags.
interface logic_unit_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  logic             iValid;
  logic             oReady;
  logic [OP_W-1:0]  iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oResult;
  logic [CNT_W-1:0] oOpCount;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             oZero;
  logic             oParity;
`endif

`ifdef LOGIC_UNIT_FLAGS_EN
  modport master (
    output iValid, iOp, iA, iB, iReady,
    input  oReady, oValid, oResult, oOpCount, oZero, oParity
  );

  modport slave (
    input  iValid, iOp, iA, iB, iReady,
    output oReady, oValid, oResult, oOpCount, oZero, oParity
  );
`else
  modport master (
    output iValid, iOp, iA, iB, iReady,
    input  oReady, oValid, oResult, oOpCount
  );

  modport slave (
    input  iValid, iOp, iA, iB, iReady,
    output oReady, oValid, oResult, oOpCount
  );
`endif

endinterface

// File: rtl/logic_pipe_reg.sv
// Generic valid/ready register slice. The slice loads whenever it is empty or
// its downstream is taking the current word, so a chain of these gives full
// throughput with backpressure and never drops or duplicates a word.
module logic_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData
);

  logic advance;

  assign advance = !oValid || iReady;
  assign oReady  = advance;

  // Capture a new word (or a bubble) only when the held word can move on.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oValid <= 1'b0;
      oData  <= '0;
    end else if (advance) begin
      oValid <= iValid;
      if (iValid) begin
        oData <= iData;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit bitwise logic unit with valid/ready handshake
// on both sides and a saturating count of delivered results.
// Stage 1 registers opcode and operands; the function is evaluated between the
// stages and stage 2 registers the result.
// Optional macro LOGIC_UNIT_FLAGS_EN adds registered zero and parity flags
// that travel with the result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic       iClk,
  input  logic       iRst_n,
  logic_unit_if.slave bus
);

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int S2_W = WIDTH + 2;
`else
  localparam int S2_W = WIDTH;
`endif
  localparam int S1_W = OP_W + 2 * WIDTH;

  function automatic logic [WIDTH-1:0] evalOp(
    input logic [OP_W-1:0]  op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = a;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end
    return c + CNT_W'(1);
  endfunction

  logic [S1_W-1:0]  data_p0;
  logic             rdy_p0;
  logic             vld_p1;
  logic [S1_W-1:0]  data_p1;
  logic             rdy_p1;
  logic [OP_W-1:0]  op_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [WIDTH-1:0] result_p1;
  logic [S2_W-1:0]  res_p1;
  logic [S2_W-1:0]  data_p2;
  logic [CNT_W-1:0] opCount;

  assign data_p0 = {bus.iOp, bus.iA, bus.iB};

  // ---- stage 1: operand register ----
  logic_pipe_reg #(.WIDTH(S1_W)) u_s1 (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iValid (bus.iValid),
    .oReady (rdy_p0),
    .iData  (data_p0),
    .oValid (vld_p1),
    .iReady (rdy_p1),
    .oData  (data_p1)
  );

  // Held off during reset so nothing is offered as accepted while the pipe clears.
  assign bus.oReady = iRst_n && rdy_p0;

  assign {op_p1, a_p1, b_p1} = data_p1;
  assign result_p1 = evalOp(op_p1, a_p1, b_p1);
`ifdef LOGIC_UNIT_FLAGS_EN
  assign res_p1 = {~|result_p1, ^result_p1, result_p1};
`else
  assign res_p1 = result_p1;
`endif

  // ---- stage 2: result register ----
  logic_pipe_reg #(.WIDTH(S2_W)) u_s2 (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iValid (vld_p1),
    .oReady (rdy_p1),
    .iData  (res_p1),
    .oValid (bus.oValid),
    .iReady (bus.iReady),
    .oData  (data_p2)
  );

`ifdef LOGIC_UNIT_FLAGS_EN
  assign {bus.oZero, bus.oParity, bus.oResult} = data_p2;
`else
  assign bus.oResult = data_p2;
`endif

  // Count each result handed downstream, sticking at the maximum value.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      opCount <= '0;
    end else if (bus.oValid && bus.iReady) begin
      opCount <= satInc(opCount);
    end
  end

  assign bus.oOpCount = opCount;

endmodule
